// File: rtl/mod_fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack fetch FSM, branch/jump redirect and flush with drain.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module mod_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        flush,
`ifdef FETCH_PERF_CNT_EN
  input  logic [31:0] flush_pc,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`else
  input  logic [31:0] flush_pc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_DRAIN} state_t;

  localparam logic [31:0] RST_PC_A = RESET_PC & ~32'h3;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drain_pc, drain_pc_nxt;
  logic        load_instr;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  // Jump beats branch; branch offset is the sign-extended word displacement.
  function automatic logic [31:0] redirect_pc(input logic [31:0] seq_pc,
                                              input logic        br,
                                              input logic [15:0] imm,
                                              input logic        jmp,
                                              input logic [25:0] tgt);
    logic signed [31:0] br_off;
    br_off = signed'({{14{imm[15]}}, imm, 2'b00});
    if (jmp)
      return {seq_pc[31:28], tgt, 2'b00};
    else if (br)
      return seq_pc + unsigned'(br_off);
    else
      return seq_pc;
  endfunction

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign pc_plus4 = pc_out + 32'd4;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    drain_pc_nxt = drain_pc;
    load_instr   = 1'b0;
    imem_req     = (state == S_REQ) || (state == S_DRAIN);
    instr_valid  = (state == S_VALID);
    imem_addr    = pc;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (flush) pc_nxt = word_align(flush_pc);
      end
      S_REQ: begin
        if (imem_ack) begin
          if (flush) begin
            pc_nxt = word_align(flush_pc);
          end else begin
            load_instr = 1'b1;
            state_nxt  = S_VALID;
          end
        end else if (flush) begin
          drain_pc_nxt = word_align(flush_pc);
          state_nxt    = S_DRAIN;
        end
      end
      S_VALID: begin
        if (flush) begin
          pc_nxt    = word_align(flush_pc);
          state_nxt = S_REQ;
        end else if (instr_ready) begin
          pc_nxt    = redirect_pc(pc_plus4, branch_taken, branch_imm, jump, jump_target);
          state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        // The outstanding request must complete at its old address; its data is dropped.
        if (flush) drain_pc_nxt = word_align(flush_pc);
        if (imem_ack) begin
          pc_nxt    = flush ? word_align(flush_pc) : drain_pc;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RST_PC_A;
      pc_out   <= RST_PC_A;
      instr    <= 32'h0;
      drain_pc <= RST_PC_A;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      drain_pc <= drain_pc_nxt;
      if (load_instr) begin
        instr  <= imem_rdata;
        pc_out <= pc;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic consume;
  assign consume = (state == S_VALID) && instr_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (consume) fetch_count <= fetch_count + 32'd1;
      if (instr_valid && !instr_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_fetch_unit.sv
// Scoreboard bench for mod_fetch_unit: expected fetch addresses and delivered instructions are queued
// by the directed stimulus and popped by a negedge monitor.
module tb_mod_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_imm = 16'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  // Memory model controls
  logic        mem_en = 1'b0;
  int          lat = 0;
  int          wcnt = 0;
  logic        ack_auto = 1'b0;
  logic [31:0] rdata_auto = 32'h0;
  logic        ack_man = 1'b0;
  logic [31:0] rdata_man = 32'h0;
  logic [31:0] fix_addr = 32'hFFFF_FFFF;
  logic [31:0] fix_data = 32'h0;

  assign imem_ack   = mem_en ? ack_auto : ack_man;
  assign imem_rdata = mem_en ? rdata_auto : rdata_man;

  logic [31:0] q_addr[$];
  logic [63:0] q_ins[$];
  int passed = 0;
  int total  = 0;

  mod_fetch_unit #(.RESET_PC(32'h0000_0043)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .funct(funct), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .branch_imm(branch_imm), .jump(jump), .jump_target(jump_target),
    .flush(flush),
`ifdef FETCH_PERF_CNT_EN
    .flush_pc(flush_pc), .fetch_count(fetch_count), .stall_count(stall_count)
`else
    .flush_pc(flush_pc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == fix_addr) ? fix_data : {a[9:4], 20'hA5C3E, a[7:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks after `lat` wait cycles while the request is held.
  initial forever begin
    @(posedge clk);
    #2;
    if (!mem_en || !imem_req) begin
      ack_auto = 1'b0;
      wcnt = 0;
    end else if (wcnt >= lat) begin
      ack_auto = 1'b1;
      rdata_auto = word(imem_addr);
      wcnt = 0;
    end else begin
      ack_auto = 1'b0;
      wcnt++;
    end
  end

  // Monitor: address stability, fetch address order, delivered instruction order.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] ea;
  logic [63:0] ei;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend && imem_req) check("addr_stable", imem_addr, pend_addr);
      if (imem_req && imem_ack) begin
        if (q_addr.size() == 0) check("addr_unexpected", imem_addr, 32'hFFFF_FFFF);
        else begin
          ea = q_addr.pop_front();
          check("imem_addr", imem_addr, ea);
        end
      end
      if (instr_valid && instr_ready && !flush) begin
        if (q_ins.size() == 0) check("instr_unexpected", instr, 32'hFFFF_FFFF);
        else begin
          ei = q_ins.pop_front();
          check("pc_out", pc_out, ei[63:32]);
          check("instr", instr, ei[31:0]);
          check("opcode_funct", {20'h0, opcode, funct}, {20'h0, ei[31:26], ei[5:0]});
          check("pc_plus4", pc_plus4, ei[63:32] + 32'd4);
        end
      end
      pend = imem_req && !imem_ack;
      pend_addr = imem_addr;
    end
  end

  task automatic do_reset();
    mem_en = 1'b0; ack_man = 1'b0; instr_ready = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; rst = 1'b1;
    tick();
    tick();
    check("addr_queue_empty", q_addr.size(), 0);
    check("instr_queue_empty", q_ins.size(), 0);
    q_addr.delete();
    q_ins.delete();
    rst = 1'b0;
  endtask

  task automatic start(input logic [31:0] a, input int l);
    do_reset();
    lat = l;
    mem_en = 1'b1;
    q_addr.push_back(a);
    flush = 1'b1; flush_pc = a;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 64) begin
      tick();
      n++;
    end
    if (!instr_valid) check("valid_timeout", 32'(instr_valid), 1);
  endtask

  initial begin
    int n;
    logic [31:0] i0, p0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fc0;
`endif

    // Reset state and first zero-wait fetch from RESET_PC=0x43
    do_reset();
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", instr, 0);
    check("rst_opfunct", {20'h0, opcode, funct}, 0);
    check("rst_pc_out", pc_out, 32'h40);
    check("rst_pc_plus4", pc_plus4, 32'h44);
    check("rst_addr", imem_addr, 32'h40);
`ifdef FETCH_PERF_CNT_EN
    check("rst_counts", fetch_count | stall_count, 0);
`endif
    fix_addr = 32'h40; fix_data = 32'h2008_0005;
    lat = 0; mem_en = 1'b1;
    q_addr.push_back(32'h40);
    tick();
    check("first_req", 32'(imem_req), 1);
    check("first_valid_early", 32'(instr_valid), 0);
    tick();
    check("first_valid", 32'(instr_valid), 1);
    check("first_opcode", 32'(opcode), 32'h08);
    check("first_pc_plus4", pc_plus4, 32'h44);
    q_ins.push_back({32'h40, 32'h2008_0005});
    instr_ready = 1'b1; mem_en = 1'b0;
    tick();
    instr_ready = 1'b0;
    check("seq_next_addr", imem_addr, 32'h44);

    // Sequential stream, 2 wait states
    start(32'h0, 2);
    instr_ready = 1'b1;
    for (int k = 1; k <= 2; k++) q_addr.push_back(32'(4 * k));
    for (int k = 0; k <= 2; k++) q_ins.push_back({32'(4 * k), word(32'(4 * k))});
    wait_valid(n);
    check("seq_latency", n, 3);
    for (int k = 1; k <= 2; k++) begin
      tick();
      wait_valid(n);
      check("seq_period", n + 1, 4);
    end
    mem_en = 1'b0;
    tick();
    instr_ready = 1'b0;

    // Branch, then branch+jump together (jump wins)
    start(32'h100, 0);
    q_ins.push_back({32'h100, word(32'h100)});
    wait_valid(n);
    branch_taken = 1'b1; branch_imm = 16'hFFFE; jump = 1'b1; jump_target = 26'h40;
    tick();
    check("redirect_ignored_valid", 32'(instr_valid), 1);
    check("redirect_ignored_req", 32'(imem_req), 0);
    jump = 1'b0; instr_ready = 1'b1;
    q_addr.push_back(32'h0FC);
    q_ins.push_back({32'h0FC, word(32'h0FC)});
    tick();
    instr_ready = 1'b0; branch_taken = 1'b0;
    wait_valid(n);
    branch_taken = 1'b1; jump = 1'b1; instr_ready = 1'b1;
    q_addr.push_back(32'h100);
    q_ins.push_back({32'h100, word(32'h100)});
    tick();
    instr_ready = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    wait_valid(n);
    instr_ready = 1'b1; mem_en = 1'b0;
    tick();
    instr_ready = 1'b0;
    check("plain_next_addr", imem_addr, 32'h104);

    // Flush mid-request: drain the old fetch, never present its data
    fix_addr = 32'h200; fix_data = 32'hDEAD_BEEF;
    start(32'h200, 3);
    instr_ready = 1'b1;
    tick();
    flush = 1'b1; flush_pc = 32'h83;
    tick();
    flush = 1'b0;
    check("drain_req", 32'(imem_req), 1);
    check("drain_valid", 32'(instr_valid), 0);
    q_addr.push_back(32'h80);
    q_ins.push_back({32'h80, word(32'h80)});
    wait_valid(n);
    mem_en = 1'b0;
    tick();
    instr_ready = 1'b0;

    // Flush coinciding with ack, then flush while valid
    start(32'h300, 0);
    flush = 1'b1; flush_pc = 32'h84;
    q_addr.push_back(32'h84);
    tick();
    flush = 1'b0;
    check("flush_ack_addr", imem_addr, 32'h84);
    check("flush_ack_valid", 32'(instr_valid), 0);
    tick();
    check("flush_ack_refetch_valid", 32'(instr_valid), 1);
    flush = 1'b1; flush_pc = 32'h88;
    q_addr.push_back(32'h88);
    q_ins.push_back({32'h88, word(32'h88)});
    tick();
    flush = 1'b0;
    check("flush_valid_drop", 32'(instr_valid), 0);
    check("flush_valid_addr", imem_addr, 32'h88);
    instr_ready = 1'b1;
    wait_valid(n);
    mem_en = 1'b0;
    tick();
    instr_ready = 1'b0;

    // Stall for 5 cycles while valid
    start(32'h400, 0);
    q_ins.push_back({32'h400, word(32'h400)});
    wait_valid(n);
    i0 = instr; p0 = pc_out;
    for (int k = 0; k < 5; k++) begin
      check("stall_instr", instr, i0);
      check("stall_pc", pc_out, p0);
      check("stall_no_req", 32'(imem_req), 0);
      tick();
    end
`ifdef FETCH_PERF_CNT_EN
    check("stall_count", stall_count, 5);
    fc0 = fetch_count;
`endif
    instr_ready = 1'b1; mem_en = 1'b0;
    tick();
    instr_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count_inc", fetch_count, fc0 + 32'd1);
    check("stall_count_hold", stall_count, 5);
`endif

    // Reset during drain; late ack in idle is ignored
    do_reset();
    flush = 1'b1; flush_pc = 32'h500;
    tick();
    flush = 1'b1; flush_pc = 32'h600;
    tick();
    flush = 1'b0;
    check("drain2_addr", imem_addr, 32'h500);
    rst = 1'b1;
    tick();
    rst = 1'b0; ack_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
    check("rst_drain_idle_req", 32'(imem_req), 0);
    tick();
    ack_man = 1'b0;
    check("restart_req", 32'(imem_req), 1);
    check("restart_addr", imem_addr, 32'h40);
    check("restart_valid", 32'(instr_valid), 0);
    fix_addr = 32'h40; fix_data = 32'h2008_0005;
    lat = 0; mem_en = 1'b1;
    q_addr.push_back(32'h40);
    q_ins.push_back({32'h40, 32'h2008_0005});
    instr_ready = 1'b1;
    wait_valid(n);
    mem_en = 1'b0;
    tick();
    instr_ready = 1'b0;

    do_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mod_fetch_unit.md
# mod_fetch_unit

Instruction fetch stage for the single-issue MIPS core. Holds the program counter, fetches one 32-bit word at a time from instruction memory over a req/ack handshake, and presents the instruction, with opcode and funct pre-split, to the decode stage and `mod_control_unit`. Applies branch and jump redirects when the current instruction is consumed, and supports an asynchronous-to-pipeline flush with drain of an in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] are forced to 0.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req` output 1: fetch request; held until `imem_ack`.
- `imem_addr` output 32: word-aligned fetch address; stable while `imem_req`=1.
- `imem_ack` input 1: memory returns data this cycle; may be asserted in the same cycle as `imem_req`.
- `imem_rdata` input 32: instruction word, sampled when `imem_ack`=1.
- `instr_valid` output 1: `instr` and `pc_out` hold a fetched instruction.
- `instr_ready` input 1: decode consumes the instruction when `instr_valid & instr_ready`.
- `instr` output 32: fetched instruction word.
- `opcode` output 6: `instr[31:26]`.
- `funct` output 6: `instr[5:0]`.
- `pc_out` output 32: address of `instr`.
- `pc_plus4` output 32: `pc_out + 4`.
- `branch_taken` input 1: branch resolved taken for the consumed instruction.
- `branch_imm` input 16: raw immediate of that branch.
- `jump` input 1: consumed instruction is `j`.
- `jump_target` input 26: `instr[25:0]` of that jump.
- `flush` input 1: discard the current or pending instruction and restart at `flush_pc`.
- `flush_pc` input 32: restart address; bits [1:0] ignored.
- `fetch_count` output 32: only with `FETCH_PERF_CNT_EN`.
- `stall_count` output 32: only with `FETCH_PERF_CNT_EN`.

## Operation
- States: `S_IDLE`, `S_REQ`, `S_VALID`, `S_DRAIN`.
- `S_IDLE`: entered on reset. Next cycle goes to `S_REQ` with `imem_addr = pc`.
- `S_REQ`: `imem_req`=1.
  - On `imem_ack`: latch `imem_rdata` into `instr`, set `pc_out = pc`, and go to `S_VALID`.
  - On `flush` without ack: go to `S_DRAIN` and record `flush_pc`.
  - On `flush` with ack: discard the data, set `pc = flush_pc`, and stay in `S_REQ` with the new address the next cycle.
- `S_VALID`: `instr_valid`=1; outputs hold until consumed. On consume, the next PC is selected and the block goes to `S_REQ`. Priority for next PC:
  - `jump`: `{pc_plus4[31:28], jump_target, 2'b00}`.
  - `branch_taken`: `pc_plus4 + ({{14{branch_imm[15]}}, branch_imm, 2'b00})`, modulo 2^32.
  - Otherwise: `pc_plus4`.
- `branch_taken` and `jump` are ignored unless the instruction is consumed that cycle. If both are asserted, `jump` wins.
- `flush` in `S_VALID` has priority over consume: set `pc = flush_pc`, set `instr_valid`=0 next cycle, and go to `S_REQ`.
- `S_DRAIN`: `imem_req` stays 1 at the old address until `imem_ack`. The returned data is discarded. The next state is `S_REQ` at the recorded `flush_pc`.
  - A further `flush` in `S_DRAIN` overwrites the recorded PC.
- `flush` in `S_IDLE`: load `pc = flush_pc`, then go to `S_REQ`.
- PC arithmetic wraps at 2^32: `32'hFFFF_FFFC + 4 = 0`.

## Timing
- Reset values:
  - `pc = RESET_PC & ~3`, `pc_out = RESET_PC & ~3`, `pc_plus4 = pc_out + 4`.
  - `instr = 0` (NOP), so `opcode = 0` and `funct = 0`.
  - `instr_valid`=0, `imem_req`=0, `imem_addr = pc`.
  - Counters are 0.
- Reset asserted in any state, including with a request outstanding, returns to `S_IDLE` next edge. A late `imem_ack` arriving in `S_IDLE` is ignored.
- First request: the cycle after `rst` deasserts is `S_IDLE`. `imem_req` rises the following cycle.
- Fetch latency with zero-wait memory (ack in the request cycle): `instr_valid` is 1 in the cycle after ack. With wait states, one cycle is added per stall.
- Back-to-back throughput: consume in cycle M, request in M+1, valid in M+2. Peak rate is one instruction per 2 cycles.
- `opcode`, `funct`, and `pc_plus4` are combinational from registered `instr` / `pc_out`, giving glitch-free inputs to `mod_control_unit`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_count` increments on each consumed instruction.
  - `stall_count` increments on each cycle with `instr_valid & ~instr_ready`.
  - Both are 32-bit, wrap at 2^32, and clear on `rst`.
- `FETCH_PERF_CNT_EN` undefined: both ports and the counters are absent. All other behaviour is identical.

## Test plan
- Reset with `RESET_PC`=32'h0000_0043, zero-wait memory returning 32'h2008_0005: `imem_addr`=32'h0000_0040; `instr_valid` rises 3 cycles after `rst` falls; `opcode`=6'h08, `pc_plus4`=32'h0000_0044.
- Sequential stream with `instr_ready`=1 and 2-cycle ack latency: addresses 0, 4, 8 are issued in order; each `imem_addr` is held stable until ack; one instruction every 4 cycles.
- Branch consume at `pc_out`=32'h100, `branch_imm`=16'hFFFE, `branch_taken`=1: next `imem_addr`=32'h0FC. With `jump`=1, `jump_target`=26'h40 asserted in the same cycle: next address=32'h100 (jump wins).
- `flush` with `flush_pc`=32'h80 asserted mid-request (ack 3 cycles later with data 32'hDEAD_BEEF): the data is never presented; the next request is to 32'h80; `instr_valid` stays 0 until that fetch returns.
- `instr_ready`=0 for 5 cycles while valid: `instr` and `pc_out` are stable and no `imem_req` is issued. With `FETCH_PERF_CNT_EN`: `stall_count`=5 and `fetch_count` increments by 1 on release.
- `rst` pulsed during `S_DRAIN` with ack arriving in the next cycle: the ack is ignored and the fetch restarts at `RESET_PC`.
